// File: rtl/fifo_byte_unpacker_if.sv
// Bundles the FIFO read port and the byte-stream handshake of fifo_byte_unpacker.
// master = the unpacker side, slave = the FIFO/consumer side.
interface fifo_byte_unpacker_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  fifo_rd;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_empty;
    logic [7:0]            m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;

    modport master (
        output fifo_rd, m_data, m_valid, m_last,
        input  fifo_data, fifo_empty, m_ready
    );

    modport slave (
        input  fifo_rd, m_data, m_valid, m_last,
        output fifo_data, fifo_empty, m_ready
    );
endinterface

// File: rtl/fifo_byte_unpacker.sv
// Pops one word at a time from the word FIFO and serialises it into a byte stream.
// One word outstanding at most: IDLE pops, WAIT captures fifo_data, SEND emits BYTES bytes.
module fifo_byte_unpacker #(
    parameter int DATA_WIDTH = 32,
    parameter int MSB_FIRST  = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    fifo_byte_unpacker_if.master bus,
    output logic                 o_busy,
    output logic [CNT_WIDTH-1:0] o_word_cnt
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic [IDX_W-1:0]      r_idx;
    logic [CNT_WIDTH-1:0]  r_word_cnt;
    logic                  w_fifo_rd;
    logic                  w_handshake;
    logic                  w_last;

    assign w_handshake  = (r_state == ST_SEND) && bus.m_ready;
    assign w_last       = (r_idx == LAST_IDX);
    // The emitted byte always sits at the same end, so shift toward it after each handshake.
    assign w_shift_next = (MSB_FIRST != 0) ? (r_shift << 8) : (r_shift >> 8);

    // Next-state decode and the combinational pop request (only ever in IDLE).
    always_comb begin
        w_next_state = r_state;
        w_fifo_rd    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!bus.fifo_empty && !i_rst) begin
                    w_fifo_rd    = 1'b1;
                    w_next_state = ST_WAIT;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_WAIT: w_next_state = ST_SEND;
            ST_SEND: begin
                if (w_handshake && w_last) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_SEND;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State, shift register, byte index and completed-word counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_idx      <= '0;
            r_word_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_WAIT) begin
                r_shift <= bus.fifo_data;
                r_idx   <= '0;
            end else if (w_handshake) begin
                r_shift <= w_shift_next;
                r_idx   <= r_idx + IDX_W'(1);
                if (w_last) begin
                    r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
                end
            end
        end
    end

    // Stream outputs decode only registered state, never m_ready.
    assign bus.fifo_rd = w_fifo_rd;
    assign bus.m_valid = (r_state == ST_SEND);
    assign bus.m_last  = (r_state == ST_SEND) && w_last;
    assign bus.m_data  = (MSB_FIRST != 0) ? r_shift[DATA_WIDTH-1 -: 8] : r_shift[7:0];
    assign o_busy      = (r_state != ST_IDLE);
    assign o_word_cnt  = r_word_cnt;
endmodule

// File: tb/tb_fifo_byte_unpacker.sv
// Directed bench for fifo_byte_unpacker: an LSB-first and an MSB-first instance,
// each fed by a small FIFO model, with scoreboard queues checked by monitors.
module tb_fifo_byte_unpacker;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy_a, busy_b;
    logic [15:0] cnt_a, cnt_b;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    fifo_byte_unpacker_if #(.DATA_WIDTH(32)) ifa ();
    fifo_byte_unpacker_if #(.DATA_WIDTH(32)) ifb ();

    fifo_byte_unpacker #(.DATA_WIDTH(32), .MSB_FIRST(0), .CNT_WIDTH(16)) dut_a (
        .i_clk(clk), .i_rst(rst), .bus(ifa), .o_busy(busy_a), .o_word_cnt(cnt_a));
    fifo_byte_unpacker #(.DATA_WIDTH(32), .MSB_FIRST(1), .CNT_WIDTH(16)) dut_b (
        .i_clk(clk), .i_rst(rst), .bus(ifb), .o_busy(busy_b), .o_word_cnt(cnt_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // FIFO models: data appears the cycle after an accepted pop.
    logic [31:0] mem_a [0:15];
    logic [31:0] mem_b [0:15];
    int wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0;
    logic [31:0] fdata_a = 32'h0, fdata_b = 32'h0;
    assign ifa.fifo_empty = (wr_a == rd_a);
    assign ifb.fifo_empty = (wr_b == rd_b);
    assign ifa.fifo_data  = fdata_a;
    assign ifb.fifo_data  = fdata_b;
    always @(posedge clk) begin
        if (ifa.fifo_rd) begin
            fdata_a <= mem_a[rd_a % 16];
            rd_a    <= rd_a + 1;
        end
        if (ifb.fifo_rd) begin
            fdata_b <= mem_b[rd_b % 16];
            rd_b    <= rd_b + 1;
        end
    end

    logic [8:0] exp_a [$];
    logic [8:0] exp_b [$];
    int rd_cycles [$];
    int hs_a = 0, hs_b = 0, last_hs_a = 0;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push_a(input logic [31:0] w, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
        mem_a[wr_a % 16] = w;
        exp_a.push_back({1'b0, b0});
        exp_a.push_back({1'b0, b1});
        exp_a.push_back({1'b0, b2});
        exp_a.push_back({1'b1, b3});
        wr_a = wr_a + 1;
    endtask

    task automatic push_b(input logic [31:0] w, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
        mem_b[wr_b % 16] = w;
        exp_b.push_back({1'b0, b0});
        exp_b.push_back({1'b0, b1});
        exp_b.push_back({1'b0, b2});
        exp_b.push_back({1'b1, b3});
        wr_b = wr_b + 1;
    endtask

    task automatic wait_hs_a(input int target, input int budget, input string name);
        int n = 0;
        while (hs_a < target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check(hs_a >= target, name, 32'(hs_a), 32'(target));
    endtask

    // Monitor A: scoreboard, pop latency, stall stability, no pop while busy.
    bit         pend_first = 1'b0;
    int         rd_cyc = 0;
    bit         prev_stall = 1'b0;
    logic [8:0] prev_byte = 9'h0;
    always @(negedge clk) begin
        if (rst) begin
            pend_first = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (ifa.fifo_rd) begin
                rd_cycles.push_back(cyc);
                check(!ifa.m_valid && !busy_a, "pop_only_idle", {30'h0, ifa.m_valid, busy_a}, 32'h0);
                pend_first = 1'b1;
                rd_cyc = cyc;
            end
            if (ifa.m_valid) begin
                if (pend_first) begin
                    check(cyc == rd_cyc + 2, "first_byte_latency", 32'(cyc - rd_cyc), 32'd2);
                    pend_first = 1'b0;
                end
                if (prev_stall)
                    check({ifa.m_last, ifa.m_data} == prev_byte, "stall_hold",
                          {23'h0, ifa.m_last, ifa.m_data}, {23'h0, prev_byte});
                if (ifa.m_ready) begin
                    if (exp_a.size() == 0) begin
                        check(1'b0, "a_unexpected_byte", {23'h0, ifa.m_last, ifa.m_data}, 32'h0);
                    end else begin
                        logic [8:0] e;
                        e = exp_a.pop_front();
                        check({ifa.m_last, ifa.m_data} == e, "a_byte_last",
                              {23'h0, ifa.m_last, ifa.m_data}, {23'h0, e});
                    end
                    hs_a++;
                    last_hs_a = cyc;
                end
                prev_stall = !ifa.m_ready;
                prev_byte  = {ifa.m_last, ifa.m_data};
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    // Monitor B: MSB-first scoreboard.
    always @(negedge clk) begin
        if (!rst && ifb.m_valid && ifb.m_ready) begin
            if (exp_b.size() == 0) begin
                check(1'b0, "b_unexpected_byte", {23'h0, ifb.m_last, ifb.m_data}, 32'h0);
            end else begin
                logic [8:0] e;
                e = exp_b.pop_front();
                check({ifb.m_last, ifb.m_data} == e, "b_byte_last",
                      {23'h0, ifb.m_last, ifb.m_data}, {23'h0, e});
            end
            hs_b++;
        end
    end

    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        int base;
        int n;
        ifa.m_ready = 1'b0;
        ifb.m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        check(ifa.m_valid == 1'b0 && ifa.m_last == 1'b0 && busy_a == 1'b0, "reset_ctrl_a",
              {29'h0, ifa.m_valid, ifa.m_last, busy_a}, 32'h0);
        check(ifa.m_data == 8'h00, "reset_data_a", {24'h0, ifa.m_data}, 32'h0);
        check(cnt_a == 16'h0 && cnt_b == 16'h0, "reset_cnt", {cnt_a, cnt_b}, 32'h0);
        check(ifa.fifo_rd == 1'b0 && ifb.fifo_rd == 1'b0 && busy_b == 1'b0, "reset_rd",
              {29'h0, ifa.fifo_rd, ifb.fifo_rd, busy_b}, 32'h0);
        rst = 1'b0;

        // Empty FIFO for 20 cycles
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check(!ifa.fifo_rd && !ifa.m_valid && !busy_a, "empty_idle",
                  {29'h0, ifa.fifo_rd, ifa.m_valid, busy_a}, 32'h0);
        end

        // Single word LSB-first
        ifa.m_ready = 1'b1;
        push_a(32'h44332211, 8'h11, 8'h22, 8'h33, 8'h44);
        wait_hs_a(4, 20, "single_hs");
        check(cnt_a == 16'd1, "single_cnt", {16'h0, cnt_a}, 32'd1);
        check(busy_a == 1'b0, "single_busy", {31'h0, busy_a}, 32'h0);

        // Single word MSB-first
        ifb.m_ready = 1'b1;
        push_b(32'h44332211, 8'h44, 8'h33, 8'h22, 8'h11);
        n = 0;
        while (hs_b < 4 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check(hs_b == 4, "msb_hs", 32'(hs_b), 32'd4);
        check(cnt_b == 16'd1 && busy_b == 1'b0, "msb_cnt", {15'h0, busy_b, cnt_b}, 32'd1);

        // Backpressure
        ifa.m_ready = 1'b0;
        base = hs_a;
        push_a(32'hA1B2C3D4, 8'hD4, 8'hC3, 8'hB2, 8'hA1);
        n = 0;
        while (!ifa.m_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check(ifa.m_valid == 1'b1, "bp_valid_seen", {31'h0, ifa.m_valid}, 32'd1);
        for (int i = 0; i < 7; i++) begin
            ifa.m_ready = pat[i];
            @(posedge clk); #1;
        end
        check(hs_a - base == 4, "bp_handshakes", 32'(hs_a - base), 32'd4);
        check(cnt_a == 16'd2 && busy_a == 1'b0, "bp_cnt", {15'h0, busy_a, cnt_a}, 32'd2);

        // Back-to-back
        ifa.m_ready = 1'b1;
        rd_cycles.delete();
        base = hs_a;
        push_a(32'hDEADBEEF, 8'hEF, 8'hBE, 8'hAD, 8'hDE);
        push_a(32'h01234567, 8'h67, 8'h45, 8'h23, 8'h01);
        push_a(32'hCAFEF00D, 8'h0D, 8'hF0, 8'hFE, 8'hCA);
        wait_hs_a(base + 12, 40, "b2b_hs");
        check(rd_cycles.size() == 3, "b2b_pops", 32'(rd_cycles.size()), 32'd3);
        if (rd_cycles.size() == 3) begin
            check(rd_cycles[1] - rd_cycles[0] == 6, "b2b_gap1", 32'(rd_cycles[1] - rd_cycles[0]), 32'd6);
            check(rd_cycles[2] - rd_cycles[1] == 6, "b2b_gap2", 32'(rd_cycles[2] - rd_cycles[1]), 32'd6);
            check(last_hs_a - rd_cycles[0] == 17, "b2b_span", 32'(last_hs_a - rd_cycles[0]), 32'd17);
        end
        check(cnt_a == 16'd5, "b2b_cnt", {16'h0, cnt_a}, 32'd5);

        // Reset after the second byte
        base = hs_a;
        push_a(32'h88776655, 8'h55, 8'h66, 8'h77, 8'h88);
        push_a(32'h00000001, 8'h01, 8'h00, 8'h00, 8'h00);
        n = 0;
        while (hs_a < base + 2 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check(hs_a == base + 2, "rst_two_bytes", 32'(hs_a - base), 32'd2);
        rst = 1'b1;
        if (exp_a.size() >= 2) begin
            void'(exp_a.pop_front());
            void'(exp_a.pop_front());
        end
        @(posedge clk); #1;
        check(ifa.m_valid == 1'b0 && busy_a == 1'b0, "rst_mid_valid", {30'h0, ifa.m_valid, busy_a}, 32'h0);
        check(cnt_a == 16'd0, "rst_mid_cnt", {16'h0, cnt_a}, 32'h0);
        check(ifa.fifo_rd == 1'b0, "rst_blocks_pop", {31'h0, ifa.fifo_rd}, 32'h0);
        rst = 1'b0;
        wait_hs_a(base + 6, 20, "post_rst_hs");
        check(cnt_a == 16'd1, "post_rst_cnt", {16'h0, cnt_a}, 32'd1);

        repeat (3) @(posedge clk);
        #1;
        check(exp_a.size() == 0 && exp_b.size() == 0, "scoreboard_drained",
              32'(exp_a.size() + exp_b.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
